// File: rtl/tadc_pkg.sv
// rtl/tadc_pkg.sv - shared types and default constants for the time-domain ADC receive side
package tadc_pkg;

  // Conversion sequencer states
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    START   = 2'd1,
    MEASURE = 2'd2,
    HOLD    = 2'd3
  } tadc_state_t;

  localparam int TADC_CNT_W       = 12;
  localparam int TADC_START_W     = 4;
  localparam int TADC_SYNC_STAGES = 2;

endpackage

// File: rtl/tadc_sync.sv
// rtl/tadc_sync.sv - N-stage reset-to-0 level synchronizer for analog-domain flags
//
// Ports:
//   clk  - destination clock
//   rst  - synchronous active-high reset, clears every stage
//   d_i  - asynchronous level input
//   q_o  - synchronized level, STAGES cycles behind d_i
module tadc_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  assign sync_d = {sync_q[STAGES-2:0], d_i};

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/tadc_tdc_ctrl.sv
// rtl/tadc_tdc_ctrl.sv - start-pulse / stop-count sequencer with valid/ready result port
//
// Ports:
//   clk, rst      - single clock, synchronous active-high reset
//   conv_req      - one-shot conversion request (pulse, remembered until serviced)
//   cont          - continuous mode, re-arm whenever idle
//   stop_i        - asynchronous comparator level from the analog macro
//   start_o       - ramp start pulse, START_W cycles long
//   busy          - conversion in progress (START, MEASURE, HOLD)
//   result        - captured cycle count
//   overflow      - no stop seen before the counter saturated
//   result_valid  - result/overflow are presented
//   result_ready  - consumer accepts the presented result
module tadc_tdc_ctrl
  import tadc_pkg::*;
#(
  parameter int CNT_W       = TADC_CNT_W,
  parameter int START_W     = TADC_START_W,
  parameter int SYNC_STAGES = TADC_SYNC_STAGES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             conv_req,
  input  logic             cont,
  input  logic             stop_i,
  output logic             start_o,
  output logic             busy,
  output logic [CNT_W-1:0] result,
  output logic             overflow,
  output logic             result_valid,
  input  logic             result_ready
);

  // Counter value in the last START cycle; counter doubles as the start-pulse timer.
  localparam logic [CNT_W-1:0] START_LAST = CNT_W'(START_W - 1);

  tadc_state_t      state_q, state_d;
  logic [CNT_W-1:0] counter_q, counter_d;
  logic [CNT_W-1:0] result_q, result_d;
  logic             overflow_q, overflow_d;
  logic             req_pend_q, req_pend_d;
  logic             stop_s;
  logic             cnt_max;

  tadc_sync #(
    .STAGES (SYNC_STAGES)
  ) u_stop_sync (
    .clk (clk),
    .rst (rst),
    .d_i (stop_i),
    .q_o (stop_s)
  );

  assign cnt_max = &counter_q;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if ((req_pend_q | cont) & ~stop_s) state_d = START;
      START:   if (counter_q == START_LAST)       state_d = MEASURE;
      MEASURE: if (stop_s | cnt_max)              state_d = HOLD;
      HOLD:    if (result_ready)                  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    start_o      = 1'b0;
    busy         = 1'b0;
    result_valid = 1'b0;
    case (state_q)
      START: begin
        start_o = 1'b1;
        busy    = 1'b1;
      end
      MEASURE: busy = 1'b1;
      HOLD: begin
        busy         = 1'b1;
        result_valid = 1'b1;
      end
      default: ;
    endcase
  end

  // Counter, capture and request-pending datapath
  always_comb begin
    counter_d  = counter_q;
    result_d   = result_q;
    overflow_d = overflow_q;
    req_pend_d = req_pend_q;

    if ((state_q == IDLE) && (state_d == START)) begin
      counter_d  = '0;
      req_pend_d = 1'b0;
    end
    // A request arriving on the entry cycle merges into the pending flag rather than being lost.
    if (conv_req) begin
      req_pend_d = 1'b1;
    end

    case (state_q)
      START: counter_d = counter_q + CNT_W'(1);
      MEASURE: begin
        if (stop_s) begin
          result_d   = counter_q;
          overflow_d = 1'b0;
        end else if (cnt_max) begin
          result_d   = '1;
          overflow_d = 1'b1;
        end else begin
          // Only increment while staying in MEASURE so the counter never wraps.
          counter_d = counter_q + CNT_W'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      counter_q  <= '0;
      result_q   <= '0;
      overflow_q <= 1'b0;
      req_pend_q <= 1'b0;
    end else begin
      counter_q  <= counter_d;
      result_q   <= result_d;
      overflow_q <= overflow_d;
      req_pend_q <= req_pend_d;
    end
  end

  assign result   = result_q;
  assign overflow = overflow_q;

endmodule
